// File: rtl/mod5_nibble_stream.sv
// Purpose : folds a framed MSB-first nibble stream of one-hot mod-5 residues into the residue of the whole number.
// Latency : result register valid exactly 1 cycle after the InLast nibble is accepted.
// Backpr. : InReady = !OutValid || OutReady; a held result blocks input, drain and accept may share a cycle.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   InValid/InReady   input handshake for InMod/InLast
//   InMod             one-hot residue of one nibble (bit k => residue k)
//   InLast            marks the least significant (final) nibble of a frame
//   OutValid/OutReady output handshake for the frame result
//   OutMod            one-hot residue of the frame, 5'b00000 when the frame had an error
//   OutCount          nibbles in the frame, saturating at 2**COUNT_W-1
//   OutError          some InMod of the frame was not exactly one-hot
module mod5_nibble_stream #(
    parameter int COUNT_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               InValid,
    output logic               InReady,
    input  logic [4:0]         InMod,
    input  logic               InLast,
    output logic               OutValid,
    input  logic               OutReady,
    output logic [4:0]         OutMod,
    output logic [COUNT_W-1:0] OutCount,
    output logic               OutError
);

    typedef enum logic {
        FIRST,
        MID
    } state_t;

    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    state_t             state, stateNext;
    logic [4:0]         acc, accNext;
    logic [COUNT_W-1:0] cnt, cntNext;
    logic               err, errNext;

    logic               accept;
    logic               legal;
    logic [4:0]         addend;
    logic [4:0]         baseAcc;
    logic [COUNT_W-1:0] baseCnt;
    logic               baseErr;
    logic               publish;

    // Modular addition of one-hot residues: each set bit of a rotates b
    // left by that bit's position, so the sum lands at (i + k) mod 5.
    function automatic logic [4:0] onehotAdd(input logic [4:0] a, input logic [4:0] b);
        logic [4:0] r;
        r = ({5{a[0]}} & b)
          | ({5{a[1]}} & {b[3:0], b[4]})
          | ({5{a[2]}} & {b[2:0], b[4:3]})
          | ({5{a[3]}} & {b[1:0], b[4:2]})
          | ({5{a[4]}} & {b[0],   b[4:1]});
        return r;
    endfunction

    assign InReady = !OutValid || OutReady;

    // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
    assign legal  = (InMod != 5'b00000) && ((InMod & (InMod - 5'd1)) == 5'b00000);
    assign addend = legal ? InMod : 5'b00001;

    always_comb begin
        stateNext = state;
        accNext   = acc;
        cntNext   = cnt;
        errNext   = err;
        publish   = 1'b0;
        accept    = InValid && InReady;

        // The first nibble of a frame starts from a clean accumulator, which
        // lets a new frame begin immediately after a publish without a bubble.
        if (state == FIRST) begin
            baseAcc = 5'b00001;
            baseCnt = '0;
            baseErr = 1'b0;
        end else begin
            baseAcc = acc;
            baseCnt = cnt;
            baseErr = err;
        end

        if (accept) begin
            // 16 == 1 (mod 5): shifting in a nibble is just adding its residue.
            accNext   = onehotAdd(baseAcc, addend);
            cntNext   = (baseCnt == CNT_MAX) ? CNT_MAX : baseCnt + COUNT_W'(1);
            errNext   = baseErr || !legal;
            publish   = InLast;
            stateNext = InLast ? FIRST : MID;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FIRST;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= 5'b00001;
            cnt      <= '0;
            err      <= 1'b0;
            OutValid <= 1'b0;
            OutMod   <= 5'b00001;
            OutCount <= '0;
            OutError <= 1'b0;
        end else begin
            acc <= accNext;
            cnt <= cntNext;
            err <= errNext;
            if (publish) begin
                // A publish wins over a drain in the same cycle: the new
                // result simply replaces the one being consumed.
                OutValid <= 1'b1;
                OutMod   <= errNext ? 5'b00000 : accNext;
                OutCount <= cntNext;
                OutError <= errNext;
            end else if (OutReady) begin
                OutValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mod5_nibble_stream.sv
module tb_mod5_nibble_stream;

    localparam int CW   = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          InValid;
    logic          InReady;
    logic [4:0]    InMod;
    logic          InLast;
    logic          OutValid;
    logic          OutReady;
    logic [4:0]    OutMod;
    logic [CW-1:0] OutCount;
    logic          OutError;

    always #5 clk = ~clk;

    mod5_nibble_stream #(.COUNT_W(CW)) dut (
        .clk      (clk),
        .reset    (reset),
        .InValid  (InValid),
        .InReady  (InReady),
        .InMod    (InMod),
        .InLast   (InLast),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .OutMod   (OutMod),
        .OutCount (OutCount),
        .OutError (OutError)
    );

    int nVec = 0;
    int nBad = 0;

    // Reference model: frame value tracked as an integer mod 5, output
    // register tracked as plain expected fields.
    bit         expValid = 1'b0;
    logic [4:0] expMod   = 5'b00001;
    int         expCount = 0;
    bit         expErr   = 1'b0;
    int         fRes     = 0;
    int         fLen     = 0;
    bit         fErr     = 1'b0;
    bit         modelReady;
    logic       seenReady;

    logic [CW+6:0] obsVec;
    logic [CW+6:0] expVec;
    assign obsVec = {OutValid, OutMod, OutCount, OutError};

    // One clock: drive inputs (nib < 0 means an illegal pattern 'bad'),
    // advance the model across the edge, return at the following negedge.
    task automatic cycle(input bit rst, input bit v, input int nib, input logic [4:0] bad,
                         input bit last, input bit ordy);
        bit acc;
        reset    = rst;
        InValid  = v;
        InLast   = last;
        OutReady = ordy;
        InMod    = (nib >= 0) ? 5'(1 << (nib % 5)) : bad;
        modelReady = !expValid || ordy;
        #1 seenReady = InReady;
        acc = !rst && v && modelReady;
        @(posedge clk);
        if (rst) begin
            expValid = 1'b0; expMod = 5'b00001; expCount = 0; expErr = 1'b0;
            fRes = 0; fLen = 0; fErr = 1'b0;
        end else begin
            if (acc) begin
                fRes = (fRes * 16 + ((nib >= 0) ? nib : 0)) % 5;
                fLen++;
                if (nib < 0) fErr = 1'b1;
            end
            if (acc && last) begin
                expValid = 1'b1;
                expErr   = fErr;
                expMod   = fErr ? 5'b00000 : 5'(1 << fRes);
                expCount = (fLen > CMAX) ? CMAX : fLen;
                fRes = 0; fLen = 0; fErr = 1'b0;
            end else if (ordy) begin
                expValid = 1'b0;
            end
        end
        expVec = {expValid, expMod, CW'(expCount), expErr};
        @(negedge clk);
    endtask

    task automatic test_reset();
        cycle(1, 1, 3, 5'b0, 1, 1);
        cycle(1, 1, 7, 5'b0, 0, 0);
        nVec++;
        if (obsVec !== {1'b0, 5'b00001, 3'd0, 1'b0}) begin
            nBad++; $display("FAIL reset_state: got %b want %b", obsVec, {1'b0, 5'b00001, 3'd0, 1'b0});
        end
        cycle(0, 0, 0, 5'b0, 0, 0);
        nVec++;
        if (seenReady !== 1'b1) begin
            nBad++; $display("FAIL reset_ready: got %b want 1", seenReady);
        end
    endtask

    task automatic test_basic();
        cycle(0, 1, 15, 5'b0, 0, 1);
        nVec++;
        if (OutValid !== 1'b0) begin
            nBad++; $display("FAIL basic_midframe_valid: got %b want 0", OutValid);
        end
        cycle(0, 1, 3, 5'b0, 1, 1);
        nVec++;
        if (obsVec !== {1'b1, 5'b01000, 3'd2, 1'b0}) begin
            nBad++; $display("FAIL basic_f3: got %b want %b", obsVec, {1'b1, 5'b01000, 3'd2, 1'b0});
        end
        cycle(0, 0, 0, 5'b0, 0, 1);
        nVec++;
        if (obsVec !== {1'b0, 5'b01000, 3'd2, 1'b0}) begin
            nBad++; $display("FAIL basic_drain: got %b want %b", obsVec, {1'b0, 5'b01000, 3'd2, 1'b0});
        end
    endtask

    task automatic test_back_to_back();
        cycle(0, 1, 1, 5'b0, 0, 1);
        cycle(0, 1, 2, 5'b0, 0, 1);
        cycle(0, 1, 3, 5'b0, 0, 1);
        cycle(0, 1, 4, 5'b0, 1, 1);
        nVec++;
        if (obsVec !== {1'b1, 5'b00001, 3'd4, 1'b0}) begin
            nBad++; $display("FAIL b2b_1234: got %b want %b", obsVec, {1'b1, 5'b00001, 3'd4, 1'b0});
        end
        cycle(0, 1, 7, 5'b0, 1, 1);
        nVec++;
        if (obsVec !== {1'b1, 5'b00100, 3'd1, 1'b0}) begin
            nBad++; $display("FAIL b2b_7: got %b want %b", obsVec, {1'b1, 5'b00100, 3'd1, 1'b0});
        end
        cycle(0, 1, 9, 5'b0, 1, 1);
        nVec++;
        if (obsVec !== {1'b1, 5'b10000, 3'd1, 1'b0}) begin
            nBad++; $display("FAIL b2b_9: got %b want %b", obsVec, {1'b1, 5'b10000, 3'd1, 1'b0});
        end
        cycle(0, 0, 0, 5'b0, 0, 1);
        nVec++;
        if (obsVec !== expVec) begin
            nBad++; $display("FAIL b2b_drain: got %b want %b", obsVec, expVec);
        end
    endtask

    task automatic test_backpressure();
        logic [CW+6:0] held;
        cycle(0, 1, 2, 5'b0, 0, 0);
        cycle(0, 1, 5, 5'b0, 1, 0);
        held = obsVec;
        nVec++;
        if (obsVec !== {1'b1, 5'b00100, 3'd2, 1'b0}) begin
            nBad++; $display("FAIL bp_publish: got %b want %b", obsVec, {1'b1, 5'b00100, 3'd2, 1'b0});
        end
        for (int k = 0; k < 5; k++) begin
            cycle(0, 1, 6, 5'b0, 1, 0);
            nVec++;
            if (seenReady !== 1'b0) begin
                nBad++; $display("FAIL bp_inready_hold%0d: got %b want 0", k, seenReady);
            end
            nVec++;
            if (obsVec !== held) begin
                nBad++; $display("FAIL bp_stable%0d: got %b want %b", k, obsVec, held);
            end
        end
        cycle(0, 1, 6, 5'b0, 1, 1);
        nVec++;
        if (seenReady !== 1'b1) begin
            nBad++; $display("FAIL bp_inready_release: got %b want 1", seenReady);
        end
        nVec++;
        if (obsVec !== {1'b1, 5'b00010, 3'd1, 1'b0}) begin
            nBad++; $display("FAIL bp_drain_accept: got %b want %b", obsVec, {1'b1, 5'b00010, 3'd1, 1'b0});
        end
        cycle(0, 0, 0, 5'b0, 0, 1);
        nVec++;
        if (obsVec !== expVec) begin
            nBad++; $display("FAIL bp_final_drain: got %b want %b", obsVec, expVec);
        end
    endtask

    task automatic test_illegal();
        cycle(0, 1, 1, 5'b0, 0, 1);
        cycle(0, 1, -1, 5'b00011, 0, 1);
        cycle(0, 1, 2, 5'b0, 1, 1);
        nVec++;
        if (obsVec !== {1'b1, 5'b00000, 3'd3, 1'b1}) begin
            nBad++; $display("FAIL illegal_frame: got %b want %b", obsVec, {1'b1, 5'b00000, 3'd3, 1'b1});
        end
        cycle(0, 1, 3, 5'b0, 1, 1);
        nVec++;
        if (obsVec !== {1'b1, 5'b01000, 3'd1, 1'b0}) begin
            nBad++; $display("FAIL illegal_recover: got %b want %b", obsVec, {1'b1, 5'b01000, 3'd1, 1'b0});
        end
        cycle(0, 1, -1, 5'b00000, 1, 1);
        nVec++;
        if (obsVec !== {1'b1, 5'b00000, 3'd1, 1'b1}) begin
            nBad++; $display("FAIL illegal_zero: got %b want %b", obsVec, {1'b1, 5'b00000, 3'd1, 1'b1});
        end
        cycle(0, 0, 0, 5'b0, 0, 1);
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 9; k++) cycle(0, 1, 1, 5'b0, (k == 8), 1);
        nVec++;
        if (obsVec !== {1'b1, 5'b10000, 3'd7, 1'b0}) begin
            nBad++; $display("FAIL saturation: got %b want %b", obsVec, {1'b1, 5'b10000, 3'd7, 1'b0});
        end
        cycle(0, 0, 0, 5'b0, 0, 1);
    endtask

    task automatic test_reset_midframe();
        cycle(0, 1, 2, 5'b0, 0, 1);
        cycle(0, 1, 2, 5'b0, 0, 1);
        for (int k = 0; k < 2; k++) begin
            cycle(1, 1, 4, 5'b0, 1, 0);
            nVec++;
            if (OutValid !== 1'b0) begin
                nBad++; $display("FAIL rstmid_valid%0d: got %b want 0", k, OutValid);
            end
        end
        cycle(0, 1, 1, 5'b0, 1, 1);
        nVec++;
        if (obsVec !== {1'b1, 5'b00010, 3'd1, 1'b0}) begin
            nBad++; $display("FAIL rstmid_frame: got %b want %b", obsVec, {1'b1, 5'b00010, 3'd1, 1'b0});
        end
        cycle(0, 0, 0, 5'b0, 0, 1);
    endtask

    task automatic test_random();
        logic [4:0] bad;
        int         nib;
        for (int k = 0; k < 400; k++) begin
            nib = ($urandom_range(0, 15) == 0) ? -1 : int'($urandom_range(0, 15));
            do bad = 5'($urandom); while ($countones(bad) == 1);
            cycle(0, ($urandom_range(0, 3) != 0), nib, bad,
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0));
            nVec++;
            if (seenReady !== modelReady) begin
                nBad++; $display("FAIL rand_inready%0d: got %b want %b", k, seenReady, modelReady);
            end
            nVec++;
            if (obsVec !== expVec) begin
                nBad++; $display("FAIL rand_out%0d: got %b want %b", k, obsVec, expVec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_saturation();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

endmodule

// File: doc/mod5_nibble_stream.md
Name: mod5_nibble_stream

Overview:
- Sequential consumer of per-nibble one-hot mod-5 residues, as produced by the 4-bit residue stage.
- Folds a framed stream of nibbles, MSB nibble first, into the one-hot residue mod 5 of the whole multi-nibble number.
- Relies on 16 ≡ 1 (mod 5): each nibble shift needs no reshuffle, so the running residue is a plain one-hot mod-5 sum.
- Valid/ready on both sides; the output register holds one result per frame.

Parameters:
- COUNT_W, 4, width of the nibble counter reported per frame; the counter saturates at 2**COUNT_W-1.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- InValid  input  1  InMod/InLast valid this cycle
- InReady  output  1  block accepts input this cycle
- InMod  input  5  one-hot residue of one nibble (bit k set => residue k)
- InLast  input  1  current nibble is the last (least significant) nibble of the frame
- OutValid  output  1  result register holds an unconsumed frame result
- OutReady  input  1  downstream accepts result
- OutMod  output  5  one-hot residue of the frame; 5'b00000 on error
- OutCount  output  COUNT_W  nibbles in the frame, saturating
- OutError  output  1  at least one InMod in the frame was not exactly one-hot

Behaviour:
- One clock (clk); reset is synchronous and active-high. On reset: OutValid=0, OutMod=5'b00001, OutCount=0, OutError=0. Internally: Acc=5'b00001, Cnt=0, Err=0, state=FIRST. Reset mid-frame discards the partial frame and any held result. Inputs are ignored in the reset cycle.
- Accept occurs when InValid && InReady.
- InReady = !OutValid || OutReady (combinational). A new nibble can be accepted in the same cycle a held result is drained.
- Add operation: onehot_add(a,b) is bit j = OR over i of a[i] & b[(j-i) mod 5], i.e. cyclic convolution. If the operands are one-hot, the result is one-hot.
- One-hot check: InMod is legal iff exactly one bit is set. An illegal InMod sets Err and is added as 5'b00001 (residue 0).
- State FIRST, waiting for the first nibble of a frame. On accept:
  - Base values: Acc0=00001, Cnt0=0, Err0=0.
  - Next values: Acc'=onehot_add(Acc0,InMod), Cnt'=1, Err' updated from the one-hot check.
  - If InLast=0: go to MID.
  - If InLast=1: publish the frame (see below) and stay in FIRST.
- State MID. On accept:
  - Acc'=onehot_add(Acc,InMod).
  - Cnt'=sat(Cnt+1).
  - Err' = Err OR the current nibble's illegal flag.
  - If InLast=1: publish and go to FIRST.
- Publish: in the cycle after the InLast accept:
  - OutValid=1.
  - OutMod = Err' ? 5'b00000 : Acc'.
  - OutCount=Cnt'.
  - OutError=Err'.
  - Latency from the last accept to OutValid is exactly 1 cycle.
- Output hold: while OutValid && !OutReady, OutMod/OutCount/OutError stay stable and InReady=0.
- Output drain: on OutValid && OutReady with no new publish, OutValid goes to 0 next cycle. OutMod/OutCount/OutError keep their last values.
- Simultaneous drain and publish: OutValid stays 1 and the new result replaces the old one. No bubble.
- No accept (InValid=0 or InReady=0): state, Acc, Cnt and Err are unchanged.
- Saturation: Cnt holds at 2**COUNT_W-1. This does not affect OutMod.
- Empty frames do not exist: every frame has at least one nibble.

Test Plan:
- Frame F,3 (0xF3=243) with InMod 00001 then 01000 (InLast on 2nd), OutReady=1 -> one cycle later OutValid=1, OutMod=01000 (3), OutCount=2, OutError=0.
- Frame 1,2,3,4 (0x1234=4660) with InMod 00010, 00100, 01000, 10000 -> OutMod=00001 (0), OutCount=4. Also send back-to-back frames 0x7 (00100, InLast) then 0x9 (10000, InLast) -> consecutive results 00100 then 10000 on consecutive cycles.
- Backpressure: publish with OutReady=0 for 5 cycles -> InReady=0 and outputs stable. Then raise OutReady with the next nibble presented -> drain and accept happen in the same cycle and no data is lost.
- Illegal input: frame InMod 00010, 00011, 00100 (InLast) -> OutError=1, OutMod=00000, OutCount=3. Following frame 01000 (InLast) -> OutError=0, OutMod=01000.
- Saturation with COUNT_W=3: nine nibbles, each 00010 -> OutCount=7, OutMod=10000 (9 mod 5 = 4).
- Reset mid-frame after two nibbles (00100, 00100), then frame 00010 (InLast) -> OutMod=00010, OutCount=1, OutError=0. OutValid=0 throughout reset.
